program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 204 ++++++++++++++++++++
 tb/tb_program_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Serial program loader: receives 8N1 bytes on rx and writes them into a 16 x 8
// program RAM while holding the processor in reset for the duration of a load.
module program_loader #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       load_en,
    input  logic [3:0] fetch_addr,
    output logic [7:0] instruction,
    output logic       cpu_hold,
    output logic       load_done,
    output logic [4:0] loaded_count,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic [15:0] HALF_LAST_C = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LAST_C = 16'(CLKS_PER_BIT - 1);

    rx_state_t   state_r, state_s;
    logic [15:0] baud_cnt_r, baud_cnt_s;
    logic [2:0]  bit_idx_r, bit_idx_s;
    logic [7:0]  shift_r, shift_s;
    logic        brk_wait_r, brk_wait_s;
    logic        stop_ok_s, stop_bad_s;

    logic        rx_meta_r, rx_sync_r;
    logic        load_en_prev_r;
    logic        load_rise_s, wr_en_s;
    logic [3:0]  wr_ptr_r;
    logic [4:0]  loaded_count_r;
    logic        load_done_r, cpu_hold_r, frame_err_r;
    logic [7:0]  mem_r [16];

    // Two-flop synchronizer for the asynchronous serial line; idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            brk_wait_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            brk_wait_r <= brk_wait_s;
        end
    end

    // Receive FSM next state; a bad stop bit parks in STOP until the line goes idle
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        brk_wait_s = brk_wait_r;
        stop_ok_s  = 1'b0;
        stop_bad_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_sync_r) begin
                    state_s    = START;
                    baud_cnt_s = 16'd0;
                end else begin
                    baud_cnt_s = 16'd0;
                end
            end
            START: begin
                if (baud_cnt_r == HALF_LAST_C) begin
                    baud_cnt_s = 16'd0;
                    bit_idx_s  = 3'd0;
                    if (!rx_sync_r) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt_r == FULL_LAST_C) begin
                    baud_cnt_s = 16'd0;
                    shift_s    = {rx_sync_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_s   = STOP;
                        bit_idx_s = 3'd0;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + 16'd1;
                end
            end
            STOP: begin
                if (brk_wait_r) begin
                    if (rx_sync_r) begin
                        state_s    = IDLE;
                        brk_wait_s = 1'b0;
                    end else begin
                        brk_wait_s = 1'b1;
                    end
                end else if (baud_cnt_r == FULL_LAST_C) begin
                    baud_cnt_s = 16'd0;
                    if (rx_sync_r) begin
                        stop_ok_s = 1'b1;
                        state_s   = IDLE;
                    end else begin
                        stop_bad_s = 1'b1;
                        brk_wait_s = 1'b1;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + 16'd1;
                end
            end
            default: begin
                state_s    = IDLE;
                baud_cnt_s = 16'd0;
                bit_idx_s  = 3'd0;
                brk_wait_s = 1'b0;
            end
        endcase
    end

    // A fresh session clear outranks a write landing in the same cycle
    always_comb begin
        load_rise_s = load_en & ~load_en_prev_r;
        wr_en_s     = stop_ok_s & load_en & ~load_done_r & ~load_rise_s;
    end

    // Session bookkeeping, processor hold and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_en_prev_r <= 1'b0;
            wr_ptr_r       <= 4'd0;
            loaded_count_r <= 5'd0;
            load_done_r    <= 1'b0;
            cpu_hold_r     <= 1'b0;
            frame_err_r    <= 1'b0;
        end else begin
            load_en_prev_r <= load_en;
            cpu_hold_r     <= load_en & ~load_done_r;
            frame_err_r    <= stop_bad_s;
            if (load_rise_s) begin
                wr_ptr_r       <= 4'd0;
                loaded_count_r <= 5'd0;
                load_done_r    <= 1'b0;
            end else if (wr_en_s) begin
                wr_ptr_r       <= wr_ptr_r + 4'd1;
                loaded_count_r <= loaded_count_r + 5'd1;
                if (loaded_count_r == 5'd15) begin
                    load_done_r <= 1'b1;
                end else begin
                    load_done_r <= load_done_r;
                end
            end else begin
                wr_ptr_r       <= wr_ptr_r;
                loaded_count_r <= loaded_count_r;
                load_done_r    <= load_done_r;
            end
        end
    end

    // Program RAM; cleared only by rst, never by a new session
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign instruction  = mem_r[fetch_addr];
    assign cpu_hold     = cpu_hold_r;
    assign load_done    = load_done_r;
    assign loaded_count = loaded_count_r;
    assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader at 16 clocks per serial bit.
module tb_program_loader;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       load_en;
    logic [3:0] fetch_addr;
    logic [7:0] instruction;
    logic       cpu_hold;
    logic       load_done;
    logic [4:0] loaded_count;
    logic       frame_err;

    int checks;
    int failures;
    int fe_cnt;

    program_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .load_en      (load_en),
        .fetch_addr   (fetch_addr),
        .instruction  (instruction),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .loaded_count (loaded_count),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles in which frame_err is high
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_word(input logic [3:0] a, output logic [7:0] d);
        fetch_addr = a;
        #1;
        d = instruction;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        rst = 1'b1; rx = 1'b1; load_en = 1'b0; fetch_addr = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0 || load_done !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: hold=%b done=%b ferr=%b required 0 0 0", cpu_hold, load_done, frame_err);
        end
        checks++;
        if (loaded_count !== 5'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d required 0", loaded_count);
        end
        read_word(4'd7, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL reset_mem7: got %h required 00", d);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_byte;
        logic [7:0] d;
        load_en = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL hold_rise: got %b required 1", cpu_hold);
        end
        send_byte(8'hAB, 1'b1);
        read_word(4'd0, d);
        checks++;
        if (d !== 8'hAB) begin
            failures++;
            $display("FAIL first_byte: got %h required ab", d);
        end
        checks++;
        if (loaded_count !== 5'd1 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL first_count: count=%0d done=%b required 1 0", loaded_count, load_done);
        end
    endtask

    task automatic test_glitch;
        int fe0;
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (loaded_count !== 5'd1 || (fe_cnt - fe0) !== 0) begin
            failures++;
            $display("FAIL glitch: count=%0d ferr_cycles=%0d required 1 0", loaded_count, fe_cnt - fe0);
        end
    endtask

    task automatic test_frame_error;
        int fe0;
        logic [7:0] d;
        fe0 = fe_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (CPB) @(negedge clk);
        checks++;
        if ((fe_cnt - fe0) !== 1) begin
            failures++;
            $display("FAIL ferr_pulse: cycles=%0d required 1", fe_cnt - fe0);
        end
        checks++;
        if (loaded_count !== 5'd1) begin
            failures++;
            $display("FAIL ferr_count: got %0d required 1", loaded_count);
        end
        send_byte(8'hD6, 1'b1);
        read_word(4'd1, d);
        checks++;
        if (d !== 8'hD6 || loaded_count !== 5'd2) begin
            failures++;
            $display("FAIL after_ferr: mem1=%h count=%0d required d6 2", d, loaded_count);
        end
    endtask

    task automatic test_full_load;
        logic [7:0] d;
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        load_en = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (loaded_count !== 5'd0) begin
            failures++;
            $display("FAIL session_clear: got %0d required 0", loaded_count);
        end
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b1);
        end
        checks++;
        if (load_done !== 1'b1 || loaded_count !== 5'd16 || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL full: done=%b count=%0d hold=%b required 1 16 0", load_done, loaded_count, cpu_hold);
        end
        send_byte(8'hFF, 1'b1);
        checks++;
        if (loaded_count !== 5'd16) begin
            failures++;
            $display("FAIL overflow_count: got %0d required 16", loaded_count);
        end
        for (int i = 0; i < 16; i++) begin
            read_word(4'(i), d);
            checks++;
            if (d !== 8'(i)) begin
                failures++;
                $display("FAIL full_mem%0d: got %h required %h", i, d, 8'(i));
            end
        end
        read_word(4'd5, d);
        checks++;
        if (d !== 8'h05) begin
            failures++;
            $display("FAIL fetch5: got %h required 05", d);
        end
    endtask

    task automatic test_reload_drop;
        logic [7:0] d;
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h88, 1'b1);
        load_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (loaded_count !== 5'd0 || load_done !== 1'b0 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL reload: count=%0d done=%b hold=%b required 0 0 1", loaded_count, load_done, cpu_hold);
        end
        read_word(4'd0, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL reload_mem0: got %h required 00", d);
        end
        read_word(4'd9, d);
        checks++;
        if (d !== 8'h09) begin
            failures++;
            $display("FAIL reload_mem9: got %h required 09", d);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] frame;
        logic [7:0] d;
        int bad;
        frame = 8'hE5;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        rx = frame[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0 || load_done !== 1'b0 || loaded_count !== 5'd0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst: hold=%b done=%b count=%0d ferr=%b required 0 0 0 0",
                     cpu_hold, load_done, loaded_count, frame_err);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            read_word(4'(i), d);
            if (d !== 8'h00) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL mid_rst_mem: nonzero words=%0d required 0", bad);
        end
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        read_word(4'd0, d);
        checks++;
        if (d !== 8'h5A || loaded_count !== 5'd1) begin
            failures++;
            $display("FAIL post_rst_frame: mem0=%h count=%0d required 5a 1", d, loaded_count);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        fe_cnt = 0;
        rst = 1'b1; rx = 1'b1; load_en = 1'b0; fetch_addr = 4'd0;
        test_reset;
        test_single_byte;
        test_glitch;
        test_frame_error;
        test_full_load;
        test_reload_drop;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
